// File: rtl/console_tx_responder.sv
// Console/tohost bus responder: byte writes to TXDATA are queued in a FIFO and
// shifted out as 8N1 UART frames; tohost writes are latched and pulsed.
module console_tx_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h9A10_0000,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,

  output logic        uart_tx_o,
  output logic        tohost_valid_o,
  output logic [31:0] tohost_data_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

  // Bus decode
  logic       hit;
  logic [1:0] reg_sel;
  logic       txdata_wr;
  logic       tohost_wr;
  logic       push;
  logic       pop;

  // FIFO state
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PtrW:0] wptr_q, rptr_q;
  logic [PtrW:0] level;
  logic          fifo_full, fifo_empty;
  logic [7:0]    head;

  // UART state
  uart_state_e   state_q;
  logic [CntW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          baud_last;

  // Response and tohost registers
  logic          rvalid_q, err_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          tohost_valid_q;
  logic [31:0]   tohost_data_q;
  logic [31:0]   status;

  logic unused_bits;
  assign unused_bits = ^{data_addr_i[1:0], data_be_i[3:1]};

  assign hit       = data_addr_i[31:4] == BASE_ADDR[31:4];
  assign reg_sel   = data_addr_i[3:2];
  assign txdata_wr = hit & data_we_i & (reg_sel == 2'd0);

  // Only a TXDATA write into a full FIFO is held off; full is the registered flag.
  assign data_gnt_o = data_req_i & ~(txdata_wr & fifo_full);
  assign push       = data_gnt_o & txdata_wr & data_be_i[0];
  assign tohost_wr  = data_gnt_o & hit & data_we_i & (reg_sel == 2'd2);

  assign level      = wptr_q - rptr_q;
  assign fifo_empty = wptr_q == rptr_q;
  assign fifo_full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                      (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign head       = mem_q[rptr_q[PtrW-1:0]];

  assign baud_last = baud_q == BaudLast;
  assign pop = ~fifo_empty & ((state_q == StIdle) | ((state_q == StStop) & baud_last));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[PtrW-1:0]] <= data_wdata_i[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          baud_q <= '0;
          if (pop) begin
            shift_q <= head;
            tx_q    <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= StData;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StData: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StStop: begin
          if (baud_last) begin
            baud_q <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (pop) begin
              shift_q <= head;
              tx_q    <= 1'b0;
              state_q <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign status = {16'h0, 8'(level), 5'h0, (state_q != StIdle), fifo_empty, fifo_full};

  always_comb begin
    rdata_d = '0;
    if (hit && !data_we_i) begin
      case (reg_sel)
        2'd1:    rdata_d = status;
        2'd2:    rdata_d = tohost_data_q;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q       <= 1'b0;
      err_q          <= 1'b0;
      rdata_q        <= '0;
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= '0;
    end else begin
      rvalid_q       <= data_gnt_o;
      err_q          <= data_gnt_o & ~hit;
      rdata_q        <= data_gnt_o ? rdata_d : '0;
      tohost_valid_q <= tohost_wr;
      if (tohost_wr) tohost_data_q <= data_wdata_i;
    end
  end

  assign data_rvalid_o  = rvalid_q;
  assign data_err_o     = err_q;
  assign data_rdata_o   = rdata_q;
  assign uart_tx_o      = tx_q;
  assign tohost_valid_o = tohost_valid_q;
  assign tohost_data_o  = tohost_data_q;

endmodule

// File: tb/tb_console_tx_responder.sv
// Scoreboard bench for console_tx_responder: bus responses, tohost pulses and
// UART frames are each checked by an independent monitor against queued expectations.
module tb_console_tx_responder;

  localparam int unsigned Cpb   = 4;
  localparam int unsigned Depth = 16;
  localparam logic [31:0] Base  = 32'h9A10_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_err_o;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        uart_tx_o;
  logic        tohost_valid_o;
  logic [31:0] tohost_data_o;

  console_tx_responder #(
    .BASE_ADDR   (Base),
    .FIFO_DEPTH  (Depth),
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_req_i    (data_req_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_err_o    (data_err_o),
    .data_addr_i   (data_addr_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_wdata_i  (data_wdata_i),
    .data_rdata_o  (data_rdata_o),
    .uart_tx_o     (uart_tx_o),
    .tohost_valid_o(tohost_valid_o),
    .tohost_data_o (tohost_data_o)
  );

  typedef struct {logic [31:0] rdata; logic err; int cyc;} rsp_t;
  typedef struct {logic [7:0] data; int cyc;} byte_t;
  typedef struct {logic [31:0] data; int cyc;} th_t;

  rsp_t  rsp_q[$];
  byte_t uart_q[$];
  th_t   th_q[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit rx_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Bus response monitor
  rsp_t rsp_e;
  always @(negedge clk) begin
    if (rst_n && data_rvalid_o) begin
      if (rsp_q.size() == 0) begin
        unexpected("rsp_unexpected");
      end else begin
        rsp_e = rsp_q.pop_front();
        check("rsp_cycle", cyc, rsp_e.cyc);
        check("rsp_err", {31'h0, data_err_o}, {31'h0, rsp_e.err});
        check("rsp_rdata", data_rdata_o, rsp_e.rdata);
      end
    end
  end

  // Tohost pulse monitor
  th_t th_e;
  always @(negedge clk) begin
    if (rst_n && tohost_valid_o) begin
      if (th_q.size() == 0) begin
        unexpected("tohost_unexpected");
      end else begin
        th_e = th_q.pop_front();
        check("tohost_cycle", cyc, th_e.cyc);
        check("tohost_data", tohost_data_o, th_e.data);
      end
    end
  end

  // UART line monitor: sample mid-bit, compare whole frame and its start cycle
  byte_t    ue;
  logic [9:0] frame;
  int       st;
  bit       abort;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rx_en && uart_tx_o === 1'b0) begin
        st = cyc;
        frame = '0;
        abort = 1'b0;
        for (int k = 0; k < 10 * Cpb; k++) begin
          if (!rx_en || !rst_n) begin
            abort = 1'b1;
            break;
          end
          if (k % Cpb == Cpb / 2) frame[k / Cpb] = uart_tx_o;
          if (k != 10 * Cpb - 1) @(negedge clk);
        end
        if (!abort) begin
          if (uart_q.size() == 0) begin
            unexpected("uart_unexpected");
          end else begin
            ue = uart_q.pop_front();
            check("uart_start_cycle", st, ue.cyc);
            check("uart_frame", {22'h0, frame}, {22'h0, 1'b1, ue.data, 1'b0});
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one request, hold it until granted, queue the expected response.
  task automatic bus_op(input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, output int gcyc, output int stalls);
    stalls = 0;
    gcyc = -1;
    data_req_i   = 1'b1;
    data_addr_i  = addr;
    data_we_i    = we;
    data_be_i    = be;
    data_wdata_i = wdata;
    @(negedge clk);
    while (!data_gnt_o && stalls < 5000) begin
      stalls++;
      @(negedge clk);
    end
    if (data_gnt_o) begin
      gcyc = cyc;
      rsp_q.push_back('{rdata: exp_rdata, err: exp_err, cyc: cyc + 1});
      if (addr[31:4] == Base[31:4] && we && addr[3:2] == 2'd2)
        th_q.push_back('{data: wdata, cyc: cyc + 1});
    end else begin
      checks++;
      failures++;
      $display("FAIL gnt_timeout: got gnt=0 want gnt=1 after %0d cycles", stalls);
    end
    @(posedge clk);
    #1;
    data_req_i = 1'b0;
    data_we_i  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  logic [7:0] bdat [18];
  int g, s, g0, last_g, last_s, fill_stalls, low_cnt;

  initial begin
    rst_n        = 1'b0;
    data_req_i   = 1'b0;
    data_addr_i  = '0;
    data_we_i    = 1'b0;
    data_be_i    = '0;
    data_wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_uart_tx", {31'h0, uart_tx_o}, 32'h1);
    check("reset_tohost_valid", {31'h0, tohost_valid_o}, 32'h0);
    check("reset_tohost_data", tohost_data_o, 32'h0);
    check("reset_rvalid", {31'h0, data_rvalid_o}, 32'h0);
    @(posedge clk);
    #1;
    bus_op(Base + 32'h4, 1'b0, 4'hF, 32'h0, 32'h0000_0002, 1'b0, g, s);

    // Single byte: line falls two cycles after grant
    bus_op(Base, 1'b1, 4'h1, 32'h0000_0041, 32'h0, 1'b0, g, s);
    uart_q.push_back('{data: 8'h41, cyc: g + 2});
    idle(10 * Cpb + 4);
    bus_op(Base + 32'h4, 1'b0, 4'hF, 32'h0, 32'h0000_0002, 1'b0, g, s);

    // Tohost write/readback; byte enables do not matter
    bus_op(Base + 32'h8, 1'b1, 4'hF, 32'h0000_0001, 32'h0, 1'b0, g, s);
    bus_op(Base + 32'h8, 1'b0, 4'hF, 32'h0, 32'h0000_0001, 1'b0, g, s);
    bus_op(Base + 32'h8, 1'b1, 4'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, g, s);
    bus_op(Base + 32'hA, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, g, s);

    // Decode: misses, disabled byte lane, reserved and read-only registers
    bus_op(32'h9A20_0000, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, g, s);
    bus_op(32'h9A20_0000, 1'b1, 4'hF, 32'h55, 32'h0, 1'b1, g, s);
    bus_op(32'h9A20_0008, 1'b1, 4'hF, 32'h1234_5678, 32'h0, 1'b1, g, s);
    bus_op(Base, 1'b1, 4'hE, 32'h77, 32'h0, 1'b0, g, s);
    bus_op(Base + 32'h4, 1'b0, 4'hF, 32'h0, 32'h0000_0002, 1'b0, g, s);
    bus_op(Base + 32'hC, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, g, s);
    bus_op(Base + 32'hC, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0, g, s);
    bus_op(Base, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, g, s);
    bus_op(Base + 32'h4, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0, g, s);
    bus_op(Base + 32'h4, 1'b0, 4'hF, 32'h0, 32'h0000_0002, 1'b0, g, s);
    bus_op(Base + 32'h8, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, g, s);

    // Burst of 18 bytes: 17 fill the FIFO (one already popped), the last stalls
    for (int i = 0; i < 18; i++) bdat[i] = 8'(i * 37 + 5);
    bus_op(Base, 1'b1, 4'h1, {24'h0, bdat[0]}, 32'h0, 1'b0, g0, s);
    for (int i = 0; i < 18; i++) uart_q.push_back('{data: bdat[i], cyc: g0 + 2 + i * 10 * Cpb});
    fill_stalls = 0;
    for (int i = 1; i < 18; i++) begin
      bus_op(Base, 1'b1, 4'h1, {24'h0, bdat[i]}, 32'h0, 1'b0, g, s);
      if (i < 17) fill_stalls += s;
      else begin
        last_g = g;
        last_s = s;
      end
    end
    check("burst_fill_no_stall", fill_stalls, 0);
    check("burst_stall_cycles", last_s, 25);
    check("burst_resume_cycle", last_g, g0 + 10 * Cpb + 2);
    bus_op(Base + 32'h4, 1'b0, 4'hF, 32'h0, 32'h0000_1005, 1'b0, g, s);
    idle(18 * 10 * Cpb + 10);
    bus_op(Base + 32'h4, 1'b0, 4'hF, 32'h0, 32'h0000_0002, 1'b0, g, s);

    // Asynchronous reset during the data bits of an all-zero byte
    bus_op(Base, 1'b1, 4'h1, 32'h0000_0000, 32'h0, 1'b0, g, s);
    repeat (3 * Cpb) @(posedge clk);
    @(negedge clk);
    #2;
    check("line_low_before_reset", {31'h0, uart_tx_o}, 32'h0);
    rx_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_async_uart_tx", {31'h0, uart_tx_o}, 32'h1);
    check("reset_async_rvalid", {31'h0, data_rvalid_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx_en = 1'b1;
    bus_op(Base + 32'h4, 1'b0, 4'hF, 32'h0, 32'h0000_0002, 1'b0, g, s);
    bus_op(Base + 32'h8, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, g, s);
    low_cnt = 0;
    for (int i = 0; i < 15 * Cpb; i++) begin
      @(negedge clk);
      if (uart_tx_o !== 1'b1) low_cnt++;
    end
    check("no_residual_frame", low_cnt, 0);

    idle(4);
    check("rsp_queue_drained", rsp_q.size(), 0);
    check("uart_queue_drained", uart_q.size(), 0);
    check("tohost_queue_drained", th_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
